// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, selects the next fetch address and runs the req/ack handshake with instruction memory.
// Optional macro FETCH_TIMEOUT_EN bounds the wait in S_WAIT, loads NOP_WORD and sets a sticky fetch_error.
module instruction_fetch_unit #(
  parameter int unsigned        PC_W           = 32,
  parameter int unsigned        INSTR_W        = 32,
  parameter logic [PC_W-1:0]    RESET_PC       = '0,
  parameter int unsigned        TIMEOUT_CYCLES = 15,
  parameter logic [INSTR_W-1:0] NOP_WORD       = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en_instruction_fetch,
  input  logic [1:0]         pc_src,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    return_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [5:0]         function_code,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               fetch_done,
  output logic               busy,
  output logic               fetch_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            first_q;
  logic [PC_W-1:0] target;
  logic            start, ack_load, tmo_load, timeout_hit;

  assign pc_plus1      = pc + PC_W'(1);
  assign function_code = instruction[INSTR_W-1 -: 6];

  // The very first fetch after reset always goes to RESET_PC, whatever pc_src says.
  always_comb begin
    target = pc_plus1;
    if (first_q) begin
      target = RESET_PC;
    end else begin
      case (pc_src)
        2'b00: target = pc_plus1;
        2'b01: target = branch_target;
        2'b10: target = jump_target;
        2'b11: target = return_addr;
      endcase
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    state_d  = state_q;
    start    = 1'b0;
    ack_load = 1'b0;
    tmo_load = 1'b0;
    case (state_q)
      S_IDLE: if (en_instruction_fetch) begin
        start   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (imem_ack) begin
        ack_load = 1'b1;
        state_d  = S_DONE;
      end else if (timeout_hit) begin
        tmo_load = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: if (!en_instruction_fetch) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request is a pure function of state, so an asynchronous reset drops it at once.
  always_comb begin
    imem_req = (state_q == S_WAIT);
    busy     = (state_q == S_WAIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      imem_addr   <= RESET_PC;
      instruction <= '0;
      pc          <= RESET_PC;
      fetch_done  <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      fetch_done <= ack_load | tmo_load;
      if (start) begin
        imem_addr <= target;
        first_q   <= 1'b0;
      end
      if (ack_load) begin
        instruction <= imem_rdata;
        pc          <= imem_addr;
      end else if (tmo_load) begin
        instruction <= NOP_WORD;
        pc          <= imem_addr;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Timeout fires on the edge that would bring the ack-less wait count up to TIMEOUT_CYCLES.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
    end else begin
      if (start)                               wait_cnt <= '0;
      else if (state_q == S_WAIT && !imem_ack) wait_cnt <= wait_cnt + CNT_W'(1);
      if (tmo_load) fetch_error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed steps plus randomized fetches against a PC/IR model.
// Honours FETCH_TIMEOUT_EN to choose between the timeout scenario and an unbounded-wait scenario.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic        clock;
  logic        reset_n;
  logic        en_instruction_fetch;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target, return_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [5:0]  function_code;
  logic [31:0] pc, pc_plus1;
  logic        fetch_done, busy, fetch_error;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the PC / IR / flags must hold according to the fetch rules.
  logic [31:0] m_pc, m_instr;
  bit          m_first, m_err;

  instruction_fetch_unit #(
    .PC_W(32), .INSTR_W(32), .RESET_PC(RESET_PC), .TIMEOUT_CYCLES(15), .NOP_WORD(NOP_WORD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .en_instruction_fetch(en_instruction_fetch),
    .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target),
    .return_addr(return_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .function_code(function_code), .pc(pc), .pc_plus1(pc_plus1),
    .fetch_done(fetch_done), .busy(busy), .fetch_error(fetch_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] exp_p1;
    exp_p1 = m_pc + 32'd1;
    check({tag, ".pc"},       pc,            m_pc);
    check({tag, ".instr"},    instruction,   m_instr);
    check({tag, ".pc_plus1"}, pc_plus1,      exp_p1);
    check({tag, ".fcode"},    function_code, m_instr[31:26]);
    check({tag, ".error"},    fetch_error,   m_err);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete fetch: start from S_IDLE, wait `waits` cycles, ack with `rdata`,
  // keep enable high for `hold` cycles in S_DONE (with stray acks), then return to S_IDLE.
  task automatic do_fetch(input string tag, input logic [1:0] src, input logic [31:0] br,
                          input logic [31:0] jt, input logic [31:0] ra, input int waits,
                          input logic [31:0] rdata, input int hold);
    logic [31:0] exp_addr;
    if (m_first)           exp_addr = RESET_PC;
    else if (src == 2'b00) exp_addr = m_pc + 32'd1;
    else if (src == 2'b01) exp_addr = br;
    else if (src == 2'b10) exp_addr = jt;
    else                   exp_addr = ra;

    en_instruction_fetch = 1'b1;
    pc_src = src; branch_target = br; jump_target = jt; return_addr = ra;
    tick();
    m_first = 1'b0;
    check({tag, ".req"},  imem_req,  1'b1);
    check({tag, ".busy"}, busy,      1'b1);
    check({tag, ".addr"}, imem_addr, exp_addr);

    // Late changes to the select/targets and enable must not disturb the fetch.
    pc_src = ~src; branch_target = ~br; jump_target = ~jt; return_addr = ~ra;
    en_instruction_fetch = 1'($urandom_range(0, 1));
    for (int i = 0; i < waits; i++) begin
      imem_rdata = $urandom;
      tick();
      check({tag, ".wait_req"},  imem_req,   1'b1);
      check({tag, ".wait_addr"}, imem_addr,  exp_addr);
      check({tag, ".wait_done"}, fetch_done, 1'b0);
    end

    imem_ack = 1'b1; imem_rdata = rdata;
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    m_pc = exp_addr; m_instr = rdata;
    check({tag, ".done"},     fetch_done, 1'b1);
    check({tag, ".req_drop"}, imem_req,   1'b0);
    check({tag, ".busy_drop"}, busy,      1'b0);
    check_regs(tag);

    en_instruction_fetch = 1'b1;
    for (int i = 0; i < hold; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
      tick();
      check({tag, ".hold_req"},  imem_req,   1'b0);
      check({tag, ".hold_done"}, fetch_done, 1'b0);
    end
    imem_ack = 1'b0;
    en_instruction_fetch = 1'b0;
    tick();
    check({tag, ".idle_done"}, fetch_done, 1'b0);
    check({tag, ".idle_req"},  imem_req,   1'b0);
    check_regs({tag, ".idle"});
  endtask

  initial begin
    reset_n = 1'b1; en_instruction_fetch = 1'b0; pc_src = 2'b00;
    branch_target = '0; jump_target = '0; return_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    m_first = 1'b1; m_pc = RESET_PC; m_instr = '0; m_err = 1'b0;

    #2 reset_n = 1'b0;
    tick();
    check("rst.req",  imem_req,   1'b0);
    check("rst.addr", imem_addr,  RESET_PC);
    check("rst.done", fetch_done, 1'b0);
    check("rst.busy", busy,       1'b0);
    check_regs("rst");
    #3 reset_n = 1'b1;
    tick();

    // First fetch ignores pc_src=10 and goes to RESET_PC.
    do_fetch("first", 2'b10, $urandom, 32'h40, $urandom, 2, 32'hA5A5_1234, 0);
    // Sequential increment from 0x10.
    do_fetch("to10",  2'b10, $urandom, 32'h10, $urandom, 0, $urandom, 0);
    do_fetch("inc",   2'b00, $urandom, $urandom, $urandom, 0, $urandom, 0);
    // Branch target sampled only at S_WAIT entry.
    do_fetch("branch", 2'b01, 32'h80, $urandom, $urandom, 3, $urandom, 0);
    do_fetch("ret",    2'b11, $urandom, $urandom, 32'h1234_5678, 1, $urandom, 0);
    // Wrap of PC+1.
    do_fetch("tomax", 2'b10, $urandom, 32'hFFFF_FFFF, $urandom, 0, $urandom, 0);
    do_fetch("wrap",  2'b00, $urandom, $urandom, $urandom, 1, $urandom, 0);
    // Enable held high in S_DONE: no refetch; then drop/raise fetches pc+1.
    do_fetch("hold",  2'b10, $urandom, 32'h200, $urandom, 0, $urandom, 5);
    do_fetch("after_hold", 2'b00, $urandom, $urandom, $urandom, 0, $urandom, 0);

    // Reset pulsed during S_WAIT.
    en_instruction_fetch = 1'b1; pc_src = 2'b10; jump_target = 32'h300;
    tick();
    en_instruction_fetch = 1'b0;
    check("mid.req_before", imem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid.req_async", imem_req, 1'b0);
    check("mid.busy",      busy,     1'b0);
    m_first = 1'b1; m_pc = RESET_PC; m_instr = '0; m_err = 1'b0;
    check_regs("mid.rst");
    tick();
    reset_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("late_ack.done", fetch_done, 1'b0);
      check("late_ack.req",  imem_req,   1'b0);
      check_regs("late_ack");
    end
    imem_ack = 1'b0;
    do_fetch("post_rst", 2'b01, 32'h999, $urandom, $urandom, 1, $urandom, 0);

`ifdef FETCH_TIMEOUT_EN
    begin
      logic [31:0] exp_addr;
      exp_addr = m_pc + 32'd1;
      en_instruction_fetch = 1'b1; pc_src = 2'b00;
      tick();
      en_instruction_fetch = 1'b0;
      check("tmo.addr", imem_addr, exp_addr);
      for (int i = 1; i < 15; i++) begin
        tick();
        check("tmo.wait_done", fetch_done, 1'b0);
        check("tmo.wait_req",  imem_req,   1'b1);
      end
      tick();
      m_pc = exp_addr; m_instr = NOP_WORD; m_err = 1'b1;
      check("tmo.done", fetch_done, 1'b1);
      check("tmo.req",  imem_req,   1'b0);
      check_regs("tmo");
      tick();
      check("tmo.pulse", fetch_done, 1'b0);
    end
`else
    do_fetch("long_wait", 2'b10, $urandom, 32'h777, $urandom, 20, $urandom, 0);
`endif

    for (int n = 0; n < 25; n++) begin
      do_fetch("rand", 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
               $urandom_range(0, 5), $urandom, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the multi-cycle control unit. It holds the PC and computes the next fetch address from pc_src and the branch, jump and return targets. It runs a req/ack handshake with instruction memory and latches the fetched word into the instruction register. It supplies the instruction and FunctionCode to the decode stage, and PC+1 as the CALL return address.

Parameters:
PC_W, 32, PC and instruction-memory word-address width.
INSTR_W, 32, instruction width; FunctionCode is instruction[INSTR_W-1:INSTR_W-6].
RESET_PC, 0, address of the first fetch after reset.
TIMEOUT_CYCLES, 15, wait limit; used only with FETCH_TIMEOUT_EN.
NOP_WORD, 0, word loaded on timeout.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
en_instruction_fetch  in  1  fetch enable from the control unit, level.
pc_src  in  2  next-PC select: 00 PC+1, 01 branch_target, 10 jump_target, 11 return_addr.
branch_target  in  PC_W  branch target address.
jump_target  in  PC_W  JMP/CALL target address.
return_addr  in  PC_W  RET address popped from the stack.
imem_req  out  1  instruction-memory request.
imem_addr  out  PC_W  request address, stable while imem_req is high.
imem_ack  in  1  memory has data valid this cycle.
imem_rdata  in  INSTR_W  instruction word.
instruction  out  INSTR_W  instruction register.
function_code  out  6  top 6 bits of instruction.
pc  out  PC_W  address of the instruction held in the instruction register.
pc_plus1  out  PC_W  pc+1, combinational, modulo 2^PC_W.
fetch_done  out  1  one-cycle pulse when the instruction register is updated.
busy  out  1  high in S_WAIT.
fetch_error  out  1  timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - FSM=S_IDLE; imem_req=0; imem_addr=RESET_PC; instruction=0; pc=RESET_PC.
  - fetch_done=0; busy=0; fetch_error=0; internal flag first=1.
- Reset asserted mid-transaction: request drops immediately. A late imem_ack after release is ignored because the FSM is in S_IDLE.
- States: S_IDLE, S_WAIT, S_DONE.
- S_IDLE, en_instruction_fetch=1 at an edge: compute target.
  - first=1: target=RESET_PC, pc_src ignored, first cleared.
  - otherwise target by pc_src: 00 pc+1 (wraps), 01 branch_target, 10 jump_target, 11 return_addr.
  - Register imem_addr=target; imem_req=1; go S_WAIT.
- pc_src and the target inputs are sampled only at S_IDLE entry into S_WAIT. Later changes have no effect.
- S_WAIT:
  - imem_req stays 1 and imem_addr is held.
  - imem_ack is sampled at each edge. Earliest ack is the edge after imem_req rises.
  - On ack: instruction=imem_rdata; pc=imem_addr; fetch_done=1 for one cycle; imem_req=0; go S_DONE.
- Deasserting en_instruction_fetch in S_WAIT does not abort the fetch.
- S_DONE:
  - Stay while en_instruction_fetch=1, so a held-high enable never re-fetches.
  - Go S_IDLE when en_instruction_fetch=0.
  - A new fetch starts earliest the edge after returning to S_IDLE.
- imem_ack outside S_WAIT is ignored.
- Latency: en sampled at edge 0, ack at edge k (k≥1): instruction valid and fetch_done high after edge k. Minimum 1 cycle in S_WAIT.
- instruction and pc change only on an accepted ack (or on timeout); they hold otherwise.
- function_code and pc_plus1 are derived combinationally from the instruction and pc registers.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on S_WAIT entry and increments each cycle in S_WAIT without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: instruction=NOP_WORD; pc=imem_addr; fetch_error=1 (sticky until reset); fetch_done pulses; go S_DONE.
  - Ack on the same edge as the timeout wins: normal load, no error.
- Undefined: no counter; S_WAIT waits indefinitely; fetch_error is constant 0.

Test Plan:
- Reset release, en=1, pc_src=10, jump_target=0x40, ack after 2 wait cycles:
  - imem_addr=RESET_PC=0, not 0x40; pc=0; instruction=imem_rdata.
  - fetch_done pulses exactly once.
- pc=0x10, pc_src=00, ack immediate: imem_addr=0x11; pc=0x11; pc_plus1=0x12.
- pc_src=01 with branch_target=0x80; branch_target changed to 0x90 during S_WAIT: fetch uses 0x80; pc=0x80.
- pc=0xFFFFFFFF, pc_src=00: imem_addr=0x00000000 (wrap).
- en held high for 5 cycles after fetch_done: no second imem_req. En drops then rises: a new fetch at pc+1.
- Reset pulsed during S_WAIT: imem_req=0 immediately; a late ack has no effect; the next fetch goes to RESET_PC.
- With FETCH_TIMEOUT_EN and no ack for 15 cycles: instruction=0; fetch_error=1; fetch_done pulses.
